// File: rtl/rv32_types_pkg.sv
// Shared RV32 types: opcodes, decoded control word, exec units.
// Also provides create_nop_ctrl() used as the idle/reset word.
package rv32_types;

  typedef logic [31:0] rv_instr_t;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPCODE_CUSTOM0  = 7'b0001011;

  typedef enum logic [2:0] {
    INSTR_R_TYPE,
    INSTR_I_TYPE,
    INSTR_S_TYPE,
    INSTR_B_TYPE,
    INSTR_U_TYPE,
    INSTR_J_TYPE,
    INSTR_R4_TYPE
  } instr_type_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  typedef enum logic [1:0] {
    IN1_RS1,
    IN1_PC,
    IN1_ZERO
  } alu_in1_t;

  typedef enum logic {
    IN2_RS2,
    IN2_IMM
  } alu_in2_t;

  typedef enum logic [1:0] {
    UNIT_ALU,
    UNIT_MULDIV,
    UNIT_CUSTOM
  } exec_unit_t;

  typedef enum logic [2:0] {
    MUL, MULH, MULHSU, MULHU,
    DIV, DIVU, REM, REMU
  } mul_div_op_t;

  typedef logic [2:0] custom_op_t;

  typedef struct packed {
    instr_type_t t;
    exec_unit_t  unit;
    alu_op_t     int_alu_op;
    alu_in1_t    alu_in1;
    alu_in2_t    alu_in2;
    mul_div_op_t mul_div_op;
    custom_op_t  custom_op;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        register_wb;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        invalid;
  } decoded_instr_t;

  // addi x0,x0,0
  function automatic decoded_instr_t create_nop_ctrl();
    decoded_instr_t c;
    c = '0;
    c.t          = INSTR_I_TYPE;
    c.unit       = UNIT_ALU;
    c.int_alu_op = ALU_ADD;
    c.alu_in1    = IN1_RS1;
    c.alu_in2    = IN2_IMM;
    c.mul_div_op = MUL;
    return c;
  endfunction

endpackage

// File: rtl/rv32_decode_queue_logic.sv
// Combinational RV32I/M/custom-0 decoder.
// Ports: instr_i raw word; decoded_o control word; use_rs_o {rd,rs2,rs1}.
module rv32_decode_logic
  import rv32_types::*;
#(
  parameter bit ENABLE_M      = 1'b1,
  parameter bit ENABLE_CUSTOM = 1'b1
) (
  input  rv_instr_t      instr_i,
  output decoded_instr_t decoded_o,
  output logic [2:0]     use_rs_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opc = instr_i[6:0];
  assign rd  = instr_i[11:7];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25],
                  instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31],
                  instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31],
                  instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  decoded_instr_t d;
  logic [2:0]     use_rs;
  logic           bad;
  logic           is_nop;

  always_comb begin
    d        = create_nop_ctrl();
    use_rs   = '0;
    bad      = 1'b0;
    is_nop   = 1'b0;
    d.rd     = rd;
    d.rs1    = instr_i[19:15];
    d.rs2    = instr_i[24:20];
    d.funct3 = f3;
    unique case (opc)
      OPCODE_LUI: begin
        d.t           = INSTR_U_TYPE;
        d.alu_in1     = IN1_ZERO;
        d.imm         = imm_u;
        d.register_wb = 1'b1;
      end
      OPCODE_AUIPC: begin
        d.t           = INSTR_U_TYPE;
        d.alu_in1     = IN1_PC;
        d.imm         = imm_u;
        d.register_wb = 1'b1;
      end
      OPCODE_JAL: begin
        d.t           = INSTR_J_TYPE;
        d.alu_in1     = IN1_PC;
        d.imm         = imm_j;
        d.jump        = 1'b1;
        d.register_wb = 1'b1;
      end
      OPCODE_JALR: begin
        d.imm         = imm_i;
        d.jump        = 1'b1;
        d.register_wb = 1'b1;
        use_rs[0]     = 1'b1;
      end
      OPCODE_BRANCH: begin
        d.t          = INSTR_B_TYPE;
        d.int_alu_op = ALU_SUB;
        d.alu_in2    = IN2_RS2;
        d.imm        = imm_b;
        d.branch     = 1'b1;
        use_rs[1:0]  = 2'b11;
      end
      OPCODE_LOAD: begin
        d.imm         = imm_i;
        d.mem_read    = 1'b1;
        d.register_wb = 1'b1;
        use_rs[0]     = 1'b1;
      end
      OPCODE_STORE: begin
        d.t         = INSTR_S_TYPE;
        d.imm       = imm_s;
        d.mem_write = 1'b1;
        use_rs[1:0] = 2'b11;
      end
      OPCODE_OP_IMM: begin
        d.imm         = imm_i;
        d.register_wb = 1'b1;
        use_rs[0]     = 1'b1;
        if (f3 == 3'b101 && f7[5])
          d.int_alu_op = ALU_SRA;
        else
          d.int_alu_op = alu_op_t'({1'b0, f3});
      end
      OPCODE_OP: begin
        d.t           = INSTR_R_TYPE;
        d.alu_in2     = IN2_RS2;
        d.register_wb = 1'b1;
        use_rs[1:0]   = 2'b11;
        if (f7 == 7'b0000000 || f7 == 7'b0100000)
          d.int_alu_op = alu_op_t'({f7[5], f3});
        else if (ENABLE_M && f7 == 7'b0000001) begin
          d.unit       = UNIT_MULDIV;
          d.mul_div_op = mul_div_op_t'(f3);
        end else
          bad = 1'b1;
      end
      OPCODE_CUSTOM0: begin
        if (ENABLE_CUSTOM) begin
          d.t           = INSTR_R4_TYPE;
          d.unit        = UNIT_CUSTOM;
          d.alu_in2     = IN2_RS2;
          d.custom_op   = f3;
          d.register_wb = 1'b1;
          use_rs        = 3'b111;
        end else
          bad = 1'b1;
      end
      OPCODE_MISC_MEM: is_nop = 1'b1;
      default:         bad    = 1'b1;
    endcase
    // rd is still read as rs3 for custom-0 even when x0
    if (rd == 5'd0)
      d.register_wb = 1'b0;
    if (bad || is_nop) begin
      d         = create_nop_ctrl();
      d.invalid = bad;
      use_rs    = '0;
    end
  end

  assign decoded_o = d;
  assign use_rs_o  = use_rs;

endmodule

// File: rtl/rv32_decode_queue.sv
// Decode stage + DEPTH-entry decoded-instruction FIFO.
// Ports: fetch in_* (valid/ready), issue out_* (valid/ready), flush, count.
module rv32_decode_queue
  import rv32_types::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter bit          ENABLE_M      = 1'b1,
  parameter bit          ENABLE_CUSTOM = 1'b1,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  rv_instr_t      in_instr,
  input  logic [31:0]    in_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output decoded_instr_t out_decoded,
  output logic [31:0]    out_pc,
  output logic [2:0]     out_use_rs,
  output logic [CW-1:0]  out_count
);

  decoded_instr_t dec_in;
  logic [2:0]     use_in;

  rv32_decode_logic #(
    .ENABLE_M      (ENABLE_M),
    .ENABLE_CUSTOM (ENABLE_CUSTOM)
  ) u_dec (
    .instr_i   (in_instr),
    .decoded_o (dec_in),
    .use_rs_o  (use_in)
  );

  decoded_instr_t dec_q [DEPTH];
  logic [31:0]    pc_q  [DEPTH];
  logic [2:0]     use_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready  = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)
        wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        dec_q[i] <= create_nop_ctrl();
        pc_q[i]  <= '0;
        use_q[i] <= '0;
      end
    end else if (push) begin
      dec_q[wr_ptr_q] <= dec_in;
      pc_q[wr_ptr_q]  <= in_pc;
      use_q[wr_ptr_q] <= use_in;
    end
  end

  assign out_decoded = dec_q[rd_ptr_q];
  assign out_pc      = pc_q[rd_ptr_q];
  assign out_use_rs  = use_q[rd_ptr_q];
  assign out_count   = count_q;

endmodule
